key_event: RTL and testbench
============================

# key_event

Press-pattern classifier that sits directly downstream of `key_filter`. It takes the debounced, active-low key level and emits one-cycle event pulses for single click, double click, long press and auto-repeat while held. Its outputs feed the application control logic, such as a mode selector or counter increment, which then never handles raw key timing itself.

## Interface
Parameters:
- `LONG_CNT`, default 26'd50_000_000: hold cycles before `key_long` (1 s at 50 MHz).
- `DBL_CNT`, default 26'd15_000_000: maximum release gap for a double click (300 ms).
- `REP_CNT`, default 26'd10_000_000: `key_repeat` period while held after a long press (200 ms).
- `CNT_W`, default 26: counter width. Every count must satisfy 2 ≤ count ≤ 2^CNT_W.

Ports:
- `sys_clk`  in  1  system clock, 50 MHz.
- `sys_rst`  in  1  reset; synchronous, active-high.
- `key_in`  in  1  debounced key level (the `key_filter` `key_out`), synchronous to `sys_clk`; 0 = pressed.
- `key_short`  out  1  one-cycle pulse: single click confirmed.
- `key_double`  out  1  one-cycle pulse: second press inside the gap window.
- `key_long`  out  1  one-cycle pulse: hold reached `LONG_CNT`.
- `key_repeat`  out  1  one-cycle pulse every `REP_CNT` cycles while held after `key_long`.
- `key_busy`  out  1  level; high whenever the state is not IDLE.

## Operation
- Edge detect: register `key_d` holds the previous `key_in`. A press is `key_d==1 && key_in==0`. A release is `key_in==1`.
- Shared counter `cnt` (`CNT_W` bits) clears on every state change and increments in every non-IDLE state.
- States and transitions:
  - **IDLE**: on a press, go to PRESS1.
  - **PRESS1**:
    - release → GAP.
    - `cnt==LONG_CNT-1` with `key_in==0` → pulse `key_long`, go to HOLD.
    - If release and terminal count happen in the same cycle, release wins: go to GAP, no `key_long`.
  - **GAP**:
    - press → pulse `key_double`, go to WAIT_REL.
    - `cnt==DBL_CNT-1` with no press → pulse `key_short`, go to IDLE.
    - If press and terminal count happen in the same cycle, press wins: `key_double`.
  - **WAIT_REL**: on release, go to IDLE. No long-press detection on the second press.
  - **HOLD**:
    - `cnt==REP_CNT-1` with `key_in==0` → pulse `key_repeat`, clear `cnt`.
    - release → IDLE. Release wins over the repeat terminal count.
- At most one event output is high in any cycle. Event outputs are registered.

## Timing
- Reset values: all outputs 0, state IDLE, `cnt`=0, `key_d`=1.
- Because `key_d` resets to 1, a key held low through reset release is detected as a press in the first cycle after reset.
- Reset asserted mid-operation aborts the current pattern with no pulse on any output.
- The press edge is detected in cycle t. PRESS1 is entered at t+1 with `cnt`=0.
- `key_long` is high in cycle t+LONG_CNT+1, exactly one cycle wide.
- The first `key_repeat` pulse comes REP_CNT cycles after `key_long`; later pulses follow every REP_CNT cycles.
- Release is seen in cycle r; GAP is entered at r+1. `key_short` is high at r+DBL_CNT+1 if no press arrives.
- `key_double` is high in the cycle after the second press edge is detected.
- `key_busy` goes high in the cycle after the press edge and falls in the cycle after the return to IDLE.

## Structure
- Package `key_event_pkg`:
  - state enum: IDLE, PRESS1, GAP, WAIT_REL, HOLD.
  - default count constants.
  - `CNT_W` default.
- One sub-module, `key_edge_det`: the `key_d` register plus press/release decode, reusable by other key consumers.
- FSM, counter and output registers live in `key_event`.

## Test plan
Benches override `LONG_CNT`=100, `DBL_CNT`=40, `REP_CNT`=20.
- Press 30 cycles, release, stay idle → exactly one `key_short`, 41 cycles after the release is seen; no other pulse.
- Press 30, release 20, press 30, release → one `key_double`, one cycle after the second press edge; no `key_short`.
- Hold 170 cycles → `key_long` at edge+101, then `key_repeat` at +20 and +40 and +60 after it (3 pulses), then IDLE on release.
- Release exactly at `cnt`=99 in PRESS1 → no `key_long`, GAP entered. Second press coinciding with `cnt`=39 in GAP → `key_double`.
- Assert `sys_rst` for 1 cycle during HOLD → all outputs 0 next cycle. Key still low → re-detected as a press, and `key_long` fires 101 cycles later.
- Random-length presses and gaps (1–200 cycles) checked against a cycle-accurate model → identical pulse streams; never two outputs high in one cycle.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared types and default timing constants for the key press-pattern classifier.
package key_event_pkg;

  localparam int unsigned DEF_CNT_W    = 26;
  localparam int unsigned DEF_LONG_CNT = 50_000_000;  // 1 s at 50 MHz
  localparam int unsigned DEF_DBL_CNT  = 15_000_000;  // 300 ms
  localparam int unsigned DEF_REP_CNT  = 10_000_000;  // 200 ms

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    GAP,
    WAIT_REL,
    HOLD
  } state_t;

  typedef struct packed {
    logic key_short;
    logic key_double;
    logic key_long;
    logic key_repeat;
  } evt_t;

endpackage

// File: rtl/key_edge_det.sv
// Previous-level register plus press/release decode for an active-low key.
module key_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press,
  output logic rel
);

  logic key_d;

  // Resets to "released" so a key held through reset shows up as a press.
  always_ff @(posedge clk) begin
    if (rst) key_d <= 1'b1;
    else     key_d <= key;
  end

  assign press = key_d & ~key;
  assign rel   = key;

endmodule

// File: rtl/key_event.sv
// Classifies debounced key activity into short/double/long/repeat event pulses.
module key_event
  import key_event_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned LONG_CNT = DEF_LONG_CNT,
  parameter int unsigned DBL_CNT  = DEF_DBL_CNT,
  parameter int unsigned REP_CNT  = DEF_REP_CNT
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_short,
  output logic key_double,
  output logic key_long,
  output logic key_repeat,
  output logic key_busy
);

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DBL_TC  = CNT_W'(DBL_CNT - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REP_CNT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cnt_clr;
  evt_t             evt, evt_nxt;
  logic             press, rel;

  key_edge_det u_edge (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .key   (key_in),
    .press (press),
    .rel   (rel)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
      cnt   <= '0;
      evt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      evt   <= evt_nxt;
    end
  end

  // Release/press checks come first in each state so they win over terminal counts.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    evt_nxt   = '0;
    case (state)
      IDLE: begin
        if (press) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (rel) begin
          state_nxt = GAP;
        end else if (cnt == LONG_TC) begin
          evt_nxt.key_long = 1'b1;
          state_nxt        = HOLD;
        end
      end
      GAP: begin
        if (press) begin
          evt_nxt.key_double = 1'b1;
          state_nxt          = WAIT_REL;
        end else if (cnt == DBL_TC) begin
          evt_nxt.key_short = 1'b1;
          state_nxt         = IDLE;
        end
      end
      WAIT_REL: begin
        if (rel) state_nxt = IDLE;
      end
      HOLD: begin
        if (rel) begin
          state_nxt = IDLE;
        end else if (cnt == REP_TC) begin
          evt_nxt.key_repeat = 1'b1;
          cnt_clr            = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state || cnt_clr) cnt_nxt = '0;
    else if (state != IDLE)            cnt_nxt = cnt + CNT_W'(1);
    else                               cnt_nxt = cnt;
  end

  assign key_short  = evt.key_short;
  assign key_double = evt.key_double;
  assign key_long   = evt.key_long;
  assign key_repeat = evt.key_repeat;
  assign key_busy   = (state != IDLE);

endmodule

// File: tb/tb_key_event.sv
// Randomized and directed bench for key_event against a timestamp-based reference model.
module tb_key_event;

  localparam int LONG = 100;
  localparam int DBL  = 40;
  localparam int REP  = 20;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic key_in  = 1'b1;
  logic key_short, key_double, key_long, key_repeat, key_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model: phase 0 idle, 1 first press, 2 gap, 3 second press, 4 held-long
  int         ph    = 0;
  int         since = 0;
  logic       kp    = 1'b1;
  logic [4:0] exp_v = '0;

  // observations of stimulus and DUT pulses
  logic last_key = 1'b1;
  int t_fall, t_rise, t_rst, t_short, t_double, t_long, t_rep_first, t_rep_last;
  int c_short, c_double, c_long, c_rep;

  key_event #(
    .CNT_W    (26),
    .LONG_CNT (LONG),
    .DBL_CNT  (DBL),
    .REP_CNT  (REP)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_in     (key_in),
    .key_short  (key_short),
    .key_double (key_double),
    .key_long   (key_long),
    .key_repeat (key_repeat),
    .key_busy   (key_busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic k, input int n);
    @(posedge sys_clk);
    #1 key_in = k;
    repeat (n - 1) @(posedge sys_clk);
  endtask

  task automatic clear_obs();
    c_short = 0; c_double = 0; c_long = 0; c_rep = 0;
  endtask

  task automatic pulse_rst();
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
  endtask

  // Per-cycle compare, then advance the model with the inputs the next edge will sample.
  initial begin : compare
    logic [4:0] act, nxt;
    logic pr, rl;
    int el;
    forever begin
      @(negedge sys_clk);
      cyc++;
      act = {key_short, key_double, key_long, key_repeat, key_busy};
      chk("outputs", 32'(act), 32'(exp_v));
      chk("one_hot", 32'($countones(act[4:1]) <= 1), 32'd1);

      if (key_short)  begin c_short++;  t_short  = cyc; end
      if (key_double) begin c_double++; t_double = cyc; end
      if (key_long)   begin c_long++;   t_long   = cyc; end
      if (key_repeat) begin
        if (c_rep == 0) t_rep_first = cyc;
        c_rep++;
        t_rep_last = cyc;
      end
      if (!key_in && last_key) t_fall = cyc;
      if (key_in && !last_key) t_rise = cyc;
      last_key = key_in;
      if (sys_rst) t_rst = cyc;

      nxt = '0;
      if (sys_rst) begin
        ph = 0;
        kp = 1'b1;
      end else begin
        pr = kp && !key_in;
        rl = key_in;
        el = cyc - since;
        case (ph)
          0: if (pr) begin ph = 1; since = cyc + 1; end
          1: if (rl) begin ph = 2; since = cyc + 1; end
             else if (el == LONG - 1) begin nxt[2] = 1'b1; ph = 4; since = cyc + 1; end
          2: if (pr) begin nxt[3] = 1'b1; ph = 3; since = cyc + 1; end
             else if (el == DBL - 1) begin nxt[4] = 1'b1; ph = 0; end
          3: if (rl) ph = 0;
          4: if (rl) ph = 0;
             else if (el % REP == REP - 1) nxt[1] = 1'b1;
          default: ph = 0;
        endcase
        kp = key_in;
      end
      nxt[0] = (ph != 0);
      exp_v  = nxt;
    end
  end

  initial begin : stim
    int r1;
    clear_obs();
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("reset_outputs", 32'({key_short, key_double, key_long, key_repeat, key_busy}), 32'd0);
    drive(1'b1, 10);

    // single click
    clear_obs();
    drive(1'b0, 30);
    drive(1'b1, 60);
    chk("t1_short_count", c_short, 1);
    chk("t1_short_delay", t_short - t_rise, 41);
    chk("t1_other_pulses", c_double + c_long + c_rep, 0);
    chk("t1_idle_busy", 32'(key_busy), 0);

    // double click
    clear_obs();
    drive(1'b0, 30);
    drive(1'b1, 20);
    drive(1'b0, 30);
    drive(1'b1, 60);
    chk("t2_double_count", c_double, 1);
    chk("t2_double_delay", t_double - t_fall, 1);
    chk("t2_short_count", c_short, 0);

    // long press with repeats
    clear_obs();
    drive(1'b0, 170);
    drive(1'b1, 60);
    chk("t3_long_count", c_long, 1);
    chk("t3_long_delay", t_long - t_fall, 101);
    chk("t3_rep_count", c_rep, 3);
    chk("t3_rep_first", t_rep_first - t_long, 20);
    chk("t3_rep_last", t_rep_last - t_long, 60);
    chk("t3_idle_busy", 32'(key_busy), 0);

    // release at the long terminal count; second press at the gap terminal count
    clear_obs();
    drive(1'b0, 100);
    drive(1'b1, 40);
    r1 = t_rise;
    drive(1'b0, 10);
    drive(1'b1, 60);
    chk("t4_long_count", c_long, 0);
    chk("t4_gap_align", t_fall - r1, 40);
    chk("t4_double_count", c_double, 1);
    chk("t4_double_delay", t_double - t_fall, 1);
    chk("t4_short_count", c_short, 0);

    // reset during HOLD with key still low
    clear_obs();
    drive(1'b0, 120);
    pulse_rst();
    @(negedge sys_clk);
    chk("t5_reset_outputs", 32'({key_short, key_double, key_long, key_repeat, key_busy}), 32'd0);
    clear_obs();
    drive(1'b0, 150);
    drive(1'b1, 60);
    chk("t5_long_count", c_long, 1);
    chk("t5_long_delay", t_long - t_rst, 102);

    // random presses and gaps
    for (int i = 0; i < 60; i++) begin
      drive(1'b0, int'($urandom_range(1, 200)));
      if ($urandom_range(0, 19) == 0) pulse_rst();
      drive(1'b1, int'($urandom_range(1, 200)));
    end
    drive(1'b1, 300);
    chk("final_idle_busy", 32'(key_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
